q_4phase_fifo: RTL and testbench

Q_4PHASE_FIFO -- requirements
Module: q_4phase_fifo

---
 rtl/q_pkg.sv | 37 +++
 rtl/q_sync.sv | 48 ++++
 rtl/q_4phase_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_q_4phase_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_pkg
//  Description : Shared types for the 4-phase handshake FIFO. Holds the
//                input-side and output-side FSM state encodings plus small
//                elaboration-time helpers used to size pointers/counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package q_pkg;

  // Upstream (receive) side: wait for a request, then hold the acknowledge
  // until the request returns to zero.
  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  // Downstream (send) side: present a token, wait for its acknowledge,
  // then wait for the acknowledge to return to zero before the next one.
  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_RTZ  = 2'd2
  } out_state_t;

  // Pointer width for a power-of-two slot count.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : q_pkg
`default_nettype wire

// File: rtl/q_sync.sv
`default_nettype none
// ============================================================================
//  Module      : q_sync
//  Description : Single-bit synchronizer chain of STAGES flops. STAGES=0 is a
//                straight wire for inputs already in the clk domain.
//  Ports       : clk - clock
//                rst - synchronous active-low reset, clears the chain to 0
//                d   - asynchronous input bit
//                q   - synchronized output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module q_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign q = sync_q[STAGES-1];
    end
  endgenerate

endmodule : q_sync
`default_nettype wire

// File: rtl/q_4phase_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : q_4phase_fifo
//  Description : DEPTH-slot FIFO bridging a 4-phase (return-to-zero)
//                request/acknowledge upstream port to a 4-phase downstream
//                port. Handshake inputs are synchronized into clk, storage
//                is a flop array, d_out is registered and frozen while
//                r_out is high.
//  Parameters  : WIDTH - data bits per token
//                DEPTH - token slots (power of two, >= 2)
//                SYNC  - synchronizer flops on r_in / a_out (0, 2 or 3)
//  Ports       : clk   - clock, all state changes on rising edge
//                rst   - synchronous active-low reset
//                r_in  - upstream request        d_in  - upstream data
//                a_in  - upstream acknowledge
//                r_out - downstream request      d_out - downstream data
//                a_out - downstream acknowledge
//                f     - full (count == DEPTH)   e     - empty (count == 0)
//                count - stored token count
//  Revision    : 1.0 - initial release
// ============================================================================
module q_4phase_fifo
  import q_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r_in,
  input  logic [WIDTH-1:0]           d_in,
  output logic                       a_in,
  output logic                       r_out,
  output logic [WIDTH-1:0]           d_out,
  input  logic                       a_out,
  output logic                       f,
  output logic                       e,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  // --------------------------------------------------------------------------
  // Handshake input synchronization
  // --------------------------------------------------------------------------
  logic r_s;
  logic a_s;

  q_sync #(.STAGES(SYNC)) u_sync_r (
    .clk (clk),
    .rst (rst),
    .d   (r_in),
    .q   (r_s)
  );

  q_sync #(.STAGES(SYNC)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a_out),
    .q   (a_s)
  );

  // After reset the synchronizer chain holds zeros that were never sampled
  // from r_in. 'warm' goes high once the chain has been refilled with real
  // samples, so a low r_s only counts as a genuine return-to-zero after that.
  logic warm;

  generate
    if (SYNC == 0) begin : g_warm_none
      assign warm = 1'b1;
    end else begin : g_warm_chain
      logic [SYNC-1:0] warm_q;
      logic [SYNC-1:0] warm_d;

      always_comb begin
        warm_d[0] = 1'b1;
        for (int i = 1; i < SYNC; i++) begin
          warm_d[i] = warm_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          warm_q <= '0;
        end else begin
          warm_q <= warm_d;
        end
      end

      assign warm = warm_q[SYNC-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  in_state_t        in_state_q,  in_state_d;
  out_state_t       out_state_q, out_state_d;
  logic             a_in_q,      a_in_d;
  logic             r_out_q,     r_out_d;
  logic [WIDTH-1:0] d_out_q,     d_out_d;
  logic [PW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]    count_q,     count_d;
  // Set once r_in has been observed low since reset; a request left high
  // across reset is therefore not mistaken for a new token.
  logic             armed_q,     armed_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr_en;
  logic rd_en;

  assign f = (count_q == CW'(DEPTH));
  assign e = (count_q == '0);

  assign a_in  = a_in_q;
  assign r_out = r_out_q;
  assign d_out = d_out_q;
  assign count = count_q;

  // --------------------------------------------------------------------------
  // Input FSM: accepts one token per full 4-phase cycle on the upstream side.
  // --------------------------------------------------------------------------
  always_comb begin
    in_state_d = in_state_q;
    a_in_d     = a_in_q;
    wr_en      = 1'b0;
    armed_d    = armed_q | (warm & ~r_s);

    case (in_state_q)
      IN_IDLE: begin
        // While full the request simply waits; d_in is required to stay
        // stable, so nothing is lost.
        if (r_s && armed_q && !f) begin
          wr_en      = 1'b1;
          a_in_d     = 1'b1;
          in_state_d = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!r_s) begin
          a_in_d     = 1'b0;
          in_state_d = IN_IDLE;
        end
      end
      default: begin
        a_in_d     = 1'b0;
        in_state_d = IN_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FSM: presents the head token and pops it on acknowledge.
  // --------------------------------------------------------------------------
  always_comb begin
    out_state_d = out_state_q;
    r_out_d     = r_out_q;
    d_out_d     = d_out_q;
    rd_en       = 1'b0;

    case (out_state_q)
      OUT_IDLE: begin
        // d_out is only loaded here, i.e. while r_out is low.
        if (!e) begin
          d_out_d     = mem_q[rd_ptr_q];
          r_out_d     = 1'b1;
          out_state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (a_s) begin
          rd_en       = 1'b1;
          r_out_d     = 1'b0;
          out_state_d = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!a_s) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: begin
        r_out_d     = 1'b0;
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, count and storage. Writes are blocked when full and pops only
  // occur when a token was presented, so count never leaves 0..DEPTH.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      a_in_q      <= 1'b0;
      r_out_q     <= 1'b0;
      d_out_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      a_in_q      <= a_in_d;
      r_out_q     <= r_out_d;
      d_out_q     <= d_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      armed_q     <= armed_d;
    end
  end

  // Storage is not reset; stale slots are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule : q_4phase_fifo
`default_nettype wire

// File: tb/tb_q_4phase_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_4phase_fifo
//  Description : Directed self-checking bench. dut0 runs with SYNC=0 for the
//                functional scenarios, dut2 with SYNC=2 for ack latency.
//                Accepted tokens are queued and checked in order on output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_4phase_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LIMIT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             r_in,  a_out;
  logic [WIDTH-1:0] d_in;
  logic             a_in,  r_out, f, e;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;

  logic             r_in2, a_out2;
  logic [WIDTH-1:0] d_in2;
  logic             a_in2, r_out2, f2, e2;
  logic [WIDTH-1:0] d_out2;
  logic [CW-1:0]    count2;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  q_4phase_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(0)) dut0 (
    .clk(clk), .rst(rst), .r_in(r_in), .d_in(d_in), .a_in(a_in),
    .r_out(r_out), .d_out(d_out), .a_out(a_out), .f(f), .e(e), .count(count)
  );

  q_4phase_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(2)) dut2 (
    .clk(clk), .rst(rst), .r_in(r_in2), .d_in(d_in2), .a_in(a_in2),
    .r_out(r_out2), .d_out(d_out2), .a_out(a_out2), .f(f2), .e(e2), .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_in(input logic v, input string tag);
    for (int i = 0; i < LIMIT && a_in !== v; i++) tick();
    chk(tag, {31'd0, a_in}, {31'd0, v});
  endtask

  task automatic wait_r_out(input logic v, input string tag);
    for (int i = 0; i < LIMIT && r_out !== v; i++) tick();
    chk(tag, {31'd0, r_out}, {31'd0, v});
  endtask

  // Complete an upstream handshake whose request is already raised.
  task automatic finish_push(input logic [WIDTH-1:0] data);
    wait_a_in(1'b1, "push_ack");
    exp_q.push_back(data);
    r_in = 1'b0;
    wait_a_in(1'b0, "push_ack_rtz");
  endtask

  task automatic push(input logic [WIDTH-1:0] data);
    d_in = data;
    r_in = 1'b1;
    finish_push(data);
  endtask

  task automatic pop();
    logic [WIDTH-1:0] want;
    wait_r_out(1'b1, "pop_req");
    if (exp_q.size() == 0) begin
      chk("pop_underflow", 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      chk("pop_data", {24'd0, d_out}, {24'd0, want});
    end
    a_out = 1'b1;
    wait_r_out(1'b0, "pop_req_clr");
    a_out = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_in"},  {31'd0, a_in},  32'd0);
    chk({tag, "_r_out"}, {31'd0, r_out}, 32'd0);
    chk({tag, "_d_out"}, {24'd0, d_out}, 32'd0);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
    chk({tag, "_f"},     {31'd0, f},     32'd0);
    chk({tag, "_e"},     {31'd0, e},     32'd1);
  endtask

  initial begin
    rst = 1'b0; r_in = 1'b0; a_out = 1'b0; d_in = '0;
    r_in2 = 1'b0; a_out2 = 1'b0; d_in2 = '0;

    // Reset state
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("reset");
    chk("reset2_a_in", {31'd0, a_in2}, 32'd0);
    chk("reset2_e",    {31'd0, e2},    32'd1);
    tick();

    // Single token, SYNC=0: ack one edge after request
    d_in = 8'hA5; r_in = 1'b1;
    tick();
    chk("single_ack_lat", {31'd0, a_in}, 32'd1);
    chk("single_count",   {29'd0, count}, 32'd1);
    exp_q.push_back(8'hA5);
    r_in = 1'b0;
    tick();
    chk("single_r_out", {31'd0, r_out}, 32'd1);
    pop();
    chk("single_count0", {29'd0, count}, 32'd0);
    chk("single_e",      {31'd0, e},     32'd1);

    // Fill with a_out held low; fifth request waits for a pop
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    chk("fill_f",     {31'd0, f},     32'd1);
    chk("fill_count", {29'd0, count}, 32'd4);
    d_in = 8'h14; r_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("fill_5th_noack", {31'd0, a_in},  32'd0);
    chk("fill_5th_count", {29'd0, count}, 32'd4);
    pop();
    finish_push(8'h14);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("fill_drain_e", {31'd0, e}, 32'd1);

    // Simultaneous push and pop at count=2
    push(8'h21); push(8'h22);
    wait_r_out(1'b1, "simul_req");
    chk("simul_head", {24'd0, d_out}, 32'h21);
    void'(exp_q.pop_front());
    d_in = 8'h23; r_in = 1'b1; a_out = 1'b1;
    tick();
    exp_q.push_back(8'h23);
    chk("simul_count", {29'd0, count}, 32'd2);
    chk("simul_ack",   {31'd0, a_in},  32'd1);
    chk("simul_pop",   {31'd0, r_out}, 32'd0);
    r_in = 1'b0; a_out = 1'b0;
    tick(); tick();
    pop(); pop();
    chk("simul_e", {31'd0, e}, 32'd1);

    // Wrap: tokens 0..9 through four slots
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    for (int i = DEPTH; i < 10; i++) begin
      pop();
      push(8'(i));
    end
    for (int i = 0; i < DEPTH; i++) pop();
    chk("wrap_e",     {31'd0, e},     32'd1);
    chk("wrap_count", {29'd0, count}, 32'd0);

    // Reset mid-handshake with r_in held high across it
    push(8'h31); push(8'h32); push(8'h33);
    chk("mid_r_out", {31'd0, r_out}, 32'd1);
    chk("mid_count", {29'd0, count}, 32'd3);
    d_in = 8'h34; r_in = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    chk_reset_outputs("midrst");
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_held_noack", {31'd0, a_in},  32'd0);
    chk("midrst_held_count", {29'd0, count}, 32'd0);
    r_in = 1'b0;
    tick();
    d_in = 8'h3C; r_in = 1'b1;
    tick();
    chk("midrst_toggle_ack", {31'd0, a_in}, 32'd1);
    finish_push(8'h3C);
    pop();

    // SYNC=2: a_in rises exactly 3 edges after r_in
    for (int i = 0; i < 4; i++) tick();
    d_in2 = 8'h5A; r_in2 = 1'b1;
    tick();
    chk("sync2_edge1", {31'd0, a_in2}, 32'd0);
    tick();
    chk("sync2_edge2", {31'd0, a_in2}, 32'd0);
    tick();
    chk("sync2_edge3", {31'd0, a_in2}, 32'd1);
    chk("sync2_count", {29'd0, count2}, 32'd1);
    r_in2 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("sync2_r_out", {31'd0, r_out2}, 32'd1);
    chk("sync2_d_out", {24'd0, d_out2}, 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_q_4phase_fifo
`default_nettype wire
